// File: rtl/mux10_rr_sched.sv
// Round-robin owner selection for a 10:1 mux: registered sel/gnt, 1-cycle req-to-grant latency, no backpressure.
// Define RR_TIMEOUT_EN to revoke an owner after MAX_HOLD cycles when another requester is waiting.
module mux10_rr_sched #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] req,
   output logic [3:0] sel,
   output logic [9:0] gnt,
   output logic       busy,
   output logic       expire
);

   typedef enum logic {IDLE, GRANT} state_t;

`ifdef RR_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] sel_q, sel_d;
   logic [3:0] ptr_q, ptr_d;
   logic [9:0] gnt_q, gnt_d;
   logic [7:0] hold_q, hold_d;
   logic       busy_q, busy_d;
   logic       expire_q, expire_d;

   logic [9:0] others;
   logic [3:0] after_owner;
   logic [4:0] pick_idle, pick_next;
   logic       timeout_hit;

   // Returns {found, index} of the first set bit scanning start..9 then 0..start-1.
   function automatic logic [4:0] rr_pick(input logic [9:0] r, input logic [3:0] start);
      logic [4:0] res;
      logic [4:0] idx;
      res = '0;
      for (int off = 9; off >= 0; off--) begin
         idx = {1'b0, start} + 5'(off);
         if (idx >= 5'd10) idx = idx - 5'd10;
         if (r[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
      return res;
   endfunction

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      expire_d    = 1'b0;
      others      = req & ~(10'(1) << sel_q);
      after_owner = (sel_q == 4'd9) ? 4'd0 : sel_q + 4'd1;
      pick_idle   = rr_pick(req, ptr_q);
      pick_next   = rr_pick(others, after_owner);
      timeout_hit = TIMEOUT_EN && (hold_q == HOLD_LAST);

      case (state_q)
         IDLE: begin
            if (pick_idle[4]) begin
               state_d = GRANT;
               sel_d   = pick_idle[3:0];
               gnt_d   = 10'(1) << pick_idle[3:0];
               ptr_d   = (pick_idle[3:0] == 4'd9) ? 4'd0 : pick_idle[3:0] + 4'd1;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (!req[sel_q] || (timeout_hit && pick_next[4])) begin
               if (pick_next[4]) begin
                  sel_d    = pick_next[3:0];
                  gnt_d    = 10'(1) << pick_next[3:0];
                  ptr_d    = (pick_next[3:0] == 4'd9) ? 4'd0 : pick_next[3:0] + 4'd1;
                  hold_d   = '0;
                  expire_d = req[sel_q];
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  hold_d  = '0;
               end
            end else if (timeout_hit) begin
               // Nobody else is waiting: keep the owner and start a fresh hold window.
               hold_d = '0;
            end else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase

      busy_d = |gnt_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         ptr_q    <= '0;
         gnt_q    <= '0;
         hold_q   <= '0;
         busy_q   <= 1'b0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         hold_q   <= hold_d;
         busy_q   <= busy_d;
         expire_q <= expire_d;
      end
   end

   assign sel    = sel_q;
   assign gnt    = gnt_q;
   assign busy   = busy_q;
   assign expire = expire_q;

endmodule

// File: tb/tb_mux10_rr_sched.sv
// Randomized and directed bench for mux10_rr_sched against an integer-level round-robin model.
module tb_mux10_rr_sched;

   localparam int MH = 4;
`ifdef RR_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] req;
   logic [3:0] sel;
   logic [9:0] gnt;
   logic       busy;
   logic       expire;

   int n_checks = 0;
   int n_errors = 0;

   int m_owner, m_ptr, m_hold, m_sel;
   bit m_expire;
   int owners[$];

   always #5 clk = ~clk;

   mux10_rr_sched #(.MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .sel(sel), .gnt(gnt), .busy(busy), .expire(expire)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int first_from(input logic [9:0] r, input int start);
      for (int j = 0; j < 10; j++) begin
         if (r[(start + j) % 10]) return (start + j) % 10;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_expire = 1'b0;
   endtask

   task automatic model_take(input int w);
      m_owner = w; m_sel = w; m_ptr = (w + 1) % 10; m_hold = 0;
   endtask

   task automatic model_step(input logic [9:0] r);
      int w;
      logic [9:0] r2;
      m_expire = 1'b0;
      if (m_owner < 0) begin
         w = first_from(r, m_ptr);
         if (w >= 0) model_take(w);
      end else if (!r[m_owner]) begin
         w = first_from(r, (m_owner + 1) % 10);
         if (w >= 0) model_take(w);
         else m_owner = -1;
      end else if (TMO && m_hold == MH - 1) begin
         r2 = r;
         r2[m_owner] = 1'b0;
         w = first_from(r2, (m_owner + 1) % 10);
         if (w >= 0) begin
            model_take(w);
            m_expire = 1'b1;
         end else begin
            m_hold = 0;
         end
      end else if (m_hold < 255) begin
         m_hold++;
      end
   endtask

   task automatic compare_outputs();
      check("sel", 32'(sel), 32'(m_sel));
      check("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("expire", 32'(expire), 32'(m_expire));
      check("sel_range", 32'(sel <= 4'd9), 32'd1);
   endtask

   task automatic cycle(input logic [9:0] r);
      @(negedge clk);
      compare_outputs();
      req = r;
      model_step(r);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      compare_outputs();
      rst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_expire", 32'(expire), 32'd0);
      model_reset();
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_step('0);
   endtask

   initial begin
      logic [9:0] r;
      int prev;
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      repeat (3) @(negedge clk);
      compare_outputs();
      rst_n = 1'b1;
      model_step('0);

      // Idle after reset
      repeat (20) cycle('0);

      // Single requester 3
      repeat (5) cycle(10'h008);
      repeat (3) cycle('0);
      check("single_gnt_direct", 32'(first_from(10'h3FF, m_ptr)), 32'd4);

      // Wrap-around between inputs 9 and 0, each owner drops after two cycles
      pulse_reset();
      prev = -1;
      for (int c = 0; c < 12; c++) begin
         r = 10'h201;
         if (m_owner >= 0 && m_hold == 1) r[m_owner] = 1'b0;
         cycle(r);
         if (m_owner >= 0 && m_owner != prev) owners.push_back(m_owner);
         prev = m_owner;
      end
      check("rr_len", 32'(owners.size() >= 4), 32'd1);
      if (owners.size() >= 4) begin
         check("rr_ord0", 32'(owners[0]), 32'd0);
         check("rr_ord1", 32'(owners[1]), 32'd9);
         check("rr_ord2", 32'(owners[2]), 32'd0);
         check("rr_ord3", 32'(owners[3]), 32'd9);
      end

      // Back-to-back handover 4 -> 5
      repeat (3) cycle('0);
      pulse_reset();
      repeat (3) cycle(10'h030);
      cycle(10'h020);
      @(negedge clk);
      check("b2b_gnt", 32'(gnt), 32'h020);
      check("b2b_busy", 32'(busy), 32'd1);
      compare_outputs();
      req = 10'h020;
      model_step(10'h020);

      // Random traffic with sticky requests
      r = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 10; b++) begin
            if ($urandom_range(7) == 0) r[b] = ~r[b];
         end
         if ($urandom_range(63) == 0) r = '0;
         cycle(r);
      end

      // Hold / timeout behaviour
      repeat (2) cycle('0);
      repeat (20) cycle(10'h003);
      repeat (20) cycle(10'h001);
      @(negedge clk);
      check("solo_gnt", 32'(gnt), 32'h001);
      check("solo_expire", 32'(expire), 32'd0);
      compare_outputs();
      req = 10'h001;
      model_step(10'h001);

      // Reset in the middle of a grant to input 8
      repeat (2) cycle('0);
      repeat (3) cycle(10'h100);
      pulse_reset();
      repeat (4) cycle(10'h100);
      @(negedge clk);
      compare_outputs();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mux10_rr_sched.md
# mux10_rr_sched

Round-robin scheduler that shares the 10-input mux datapath among 10 requesters. Each cycle it decides which requester owns the mux. It drives the mux's 4-bit select and a one-hot grant vector. It sits directly in front of mux_10x1 (s port) and keeps select in the legal range 0–9 at all times.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles per owner when the timeout feature is compiled in; legal range 1–255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  10  request per mux input; req[k] asks for mux input i[k].
- sel  output  4  select to the mux's s port; always 0–9.
- gnt  output  10  one-hot grant, or all-zero when idle; gnt[k] means sel==k and requester k owns the mux.
- busy  output  1  high while any grant is active (== |gnt).
- expire  output  1  one-cycle pulse on the edge a grant is revoked by timeout.

## Operation
- All outputs are registered. Reset values: sel=0, gnt=0, busy=0, expire=0. Internal pointer ptr=0, hold_cnt=0, state=IDLE.
- Search order starts at ptr and runs ptr, ptr+1, …, 9, 0, …, ptr−1. Wrap-around is 9→0 and is never 15→0. The first set req bit in this order wins.
- After each grant, ptr becomes granted index+1 (9→0).
- States:
  - IDLE: gnt=0.
    - Any req set: grant the winner, load sel, hold_cnt=0, go to GRANT.
    - No req set: stay in IDLE. sel keeps its last value.
  - GRANT: owner k holds gnt[k].
    - req[k]=1 and no timeout: stay, hold_cnt+1.
    - req[k]=0 (release): on the same edge, arbitrate among the remaining req bits, starting at k+1.
      - A winner exists: grant it directly, with no idle cycle.
      - No winner: go to IDLE, gnt=0.
    - Timeout (see Configuration): treated as a release of k, except k is excluded from that arbitration.
- Simultaneous events:
  - A new request arriving on the same edge as a release takes part in that edge's arbitration.
  - A requester that releases and re-asserts in the very next cycle is served again only after the round-robin order reaches it.
- hold_cnt is 8 bits wide and saturates at 255.
- Reset asserted mid-grant: outputs drop to their reset values asynchronously. No expire pulse is produced.

## Timing
- Latency from req to grant: req[k] sampled high at edge N makes gnt[k], sel=k and busy=1 visible after edge N.
- Owner handover: req[k] low at edge N makes gnt move to the next owner (or to 0) after edge N. There is a 1-cycle overlap in which the old requester sees its grant after dropping req.
- sel and gnt always change on the same edge. The mux output y is valid for the owner in every cycle where busy=1.
- expire is high for exactly the cycle after the revoking edge and is low otherwise.

## Configuration
- RR_TIMEOUT_EN defined:
  - In GRANT, the edge where hold_cnt==MAX_HOLD−1 and at least one other req bit is set revokes the owner. expire pulses and the next owner is granted.
  - If no other req bit is set, the owner keeps the grant and hold_cnt restarts at 0.
- RR_TIMEOUT_EN undefined:
  - The grant is held until the owner drops req. expire is tied to 0 and MAX_HOLD is ignored.

## Test plan
- Reset/idle: hold rst_n=0, then release with req=0 → sel=0, gnt=0, busy=0, expire=0 for 20 cycles.
- Single requester: req=10'h008 for 5 cycles, then 0 → gnt=10'h008 and sel=3 from the cycle after the first req edge; IDLE one cycle after req drops; ptr=4.
- Round-robin with wrap: req=10'h201 (inputs 9 and 0) held, owners drop req after 2 cycles each and re-assert → grant order 0,9,0,9 with sel 0,9,0,9; sel never reads 10–15.
- Back-to-back handover: req=10'h030, owner 4 drops → gnt moves 10'h010→10'h020 on the same edge, busy stays 1, no idle cycle.
- Timeout (RR_TIMEOUT_EN, MAX_HOLD=4): req=10'h003 held constant → owner alternates 0,1,0 every 4 cycles with an expire pulse at each switch. With req=10'h001 only, grant stays on 0 with no expire. With the macro undefined, grant stays on 0 indefinitely.
- Reset mid-grant: rst_n pulsed low while gnt=10'h100 → gnt=0 and sel=0 immediately. After release, req=10'h100 is granted again with ptr restarted at 0.
